uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter NB_DATA, default 8, meaning data bits per frame; legal 5..9.
REQ-002 Parameter NB_STOP, default 1, meaning stop bits per frame; legal 1 or 2.
REQ-003 Parameter OVERSAMPLE, default 16, meaning i_tick pulses per bit; even, legal 8..32.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-006 i_tick  in  1  oversampling strobe, one clk wide.
REQ-007 i_rx  in  1  asynchronous serial line; idle high.
REQ-008 i_parity_odd  in  1  parity sense: 1 = odd, 0 = even; present only with UART_RX_PARITY_EN.
REQ-009 o_data  out  NB_DATA  last received word, LSB = first data bit.
REQ-010 o_rxdone  out  1  one-clk pulse; frame complete.
REQ-011 o_frame_err  out  1  a stop bit of the last frame sampled 0.
REQ-012 o_parity_err  out  1  parity mismatch on the last frame; tied 0 without UART_RX_PARITY_EN.
REQ-013 o_busy  out  1  high in every state except IDLE.

Function
REQ-014 i_rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP; one-hot encoding.
REQ-016 IDLE: when rx_s = 0, go to START with tick counter = 0; no i_tick needed.
REQ-017 Tick counter advances only on cycles with i_tick = 1; with no tick, all state and counters hold.
REQ-018 START: on the tick where counter = OVERSAMPLE/2-1, if rx_s = 1 (glitch), return to IDLE with no outputs changed; else clear the counter and go to DATA.
REQ-019 DATA: on each tick where counter = OVERSAMPLE-1, shift rx_s in at the MSB (right shift, LSB first on the line) and clear the counter; after NB_DATA samples, go to PARITY if enabled, else STOP.
REQ-020 PARITY: sample at counter = OVERSAMPLE-1; error = XOR(data bits, sample) differs from i_parity_odd; go to STOP.
REQ-021 STOP: sample each stop bit at counter = OVERSAMPLE-1; a 0 on any stop bit sets the frame-error flag for the frame.
REQ-022 After the final stop sample: in the same clk edge, update o_data, o_frame_err and o_parity_err; pulse o_rxdone for exactly 1 clk; go to IDLE.
REQ-023 o_data and error outputs SHALL hold until the next o_rxdone; a glitch-rejected start leaves them unchanged.
REQ-024 Errors do not suppress o_rxdone; a frame with errors still delivers data.
REQ-025 Back-to-back frames: a start edge seen in IDLE on the clk after o_rxdone SHALL be accepted; no idle bit is required.
REQ-026 Break (line held 0): frame completes with o_data = 0 and o_frame_err = 1; the FSM then restarts from IDLE, because rx_s is still 0.
REQ-027 Latency: o_rxdone asserts on the clk edge of the tick that samples the last stop bit, plus the 2-cycle synchronizer delay relative to i_rx.

Reset
REQ-028 While i_rst_n = 0: state = IDLE; counters, shift register and sync flops cleared (sync flops to 1).
REQ-029 Outputs during reset: o_data = 0, o_rxdone = 0, o_frame_err = 0, o_parity_err = 0, o_busy = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no o_rxdone; reception restarts on the next start edge after release.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: i_parity_odd port, PARITY state and o_parity_err logic present; the frame has 1 parity bit between the data and stop bits.
REQ-032 UART_RX_PARITY_EN undefined: no i_parity_odd port, PARITY state never entered, o_parity_err constant 0.

Verification (OVERSAMPLE = 16, i_tick every 4th clk, defaults otherwise)
REQ-033 Frame 0x55 with 8N1 and a valid stop bit -> one o_rxdone pulse; o_data = 0x55; both errors 0; o_busy low after.
REQ-034 Start-bit glitch: low for 5 ticks, then high -> no o_rxdone; FSM back in IDLE; o_data unchanged.
REQ-035 Frame 0xA3 with stop bit = 0 -> o_rxdone pulses; o_data = 0xA3; o_frame_err = 1.
REQ-036 UART_RX_PARITY_EN, i_parity_odd = 0, frame 0x07 with parity bit 0 -> o_parity_err = 1; same frame with parity bit 1 -> o_parity_err = 0.
REQ-037 Two back-to-back frames 0x12 then 0x34 (NB_STOP = 2) -> two o_rxdone pulses; o_data = 0x12, then 0x34.
REQ-038 i_rst_n pulsed low during data bit 4 of a frame -> no o_rxdone; all outputs 0; next frame 0xC9 received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: 2-flop line synchronizer, one-hot framing FSM, registered results.
// Optional parity bit and o_parity_err logic are built in when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | line idle, waiting for rx_s = 0
// START  | confirming the start bit at its centre (glitch reject)
// DATA   | sampling NB_DATA data bits, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling NB_STOP stop bits, then publishing the frame
module uart_rx_cfg #(
   parameter int NB_DATA    = 8,
   parameter int NB_STOP    = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_tick,
   input  logic               i_rx,
`ifdef UART_RX_PARITY_EN
   input  logic               i_parity_odd,
`endif
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rxdone,
   output logic               o_frame_err,
   output logic               o_parity_err,
   output logic               o_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(OVERSAMPLE - 1);
   localparam logic [3:0]    LAST_DATA = 4'(NB_DATA - 1);
   localparam logic [3:0]    LAST_STOP = 4'(NB_STOP - 1);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_START  = 5'b00010,
      S_DATA   = 5'b00100,
      S_PARITY = 5'b01000,
      S_STOP   = 5'b10000
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_meta_q, rx_s_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [NB_DATA-1:0]   shift_q, shift_d;
   logic [NB_DATA-1:0]   data_q, data_d;
   logic                 stop_err_q, stop_err_d;
   logic                 ferr_q, ferr_d;
   logic                 rxdone_q, rxdone_d;
   logic                 tc;
`ifdef UART_RX_PARITY_EN
   logic                 par_pend_q, par_pend_d;
   logic                 perr_q, perr_d;
`endif

   // Down-counter reaches terminal count on the tick that samples the bit centre.
   assign tc = i_tick && (cnt_q == '0);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         stop_err_q <= 1'b0;
         ferr_q     <= 1'b0;
         rxdone_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pend_q <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         rx_meta_q  <= i_rx;
         rx_s_q     <= rx_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         stop_err_q <= stop_err_d;
         ferr_q     <= ferr_d;
         rxdone_q   <= rxdone_d;
`ifdef UART_RX_PARITY_EN
         par_pend_q <= par_pend_d;
         perr_q     <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      data_d     = data_q;
      stop_err_d = stop_err_q;
      ferr_d     = ferr_q;
      rxdone_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_d = par_pend_q;
      perr_d     = perr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d    = S_START;
               cnt_d      = CNT_HALF;
               bit_d      = '0;
               stop_err_d = 1'b0;
            end
         end
         S_START: begin
            if (i_tick && (cnt_q != '0)) begin
               cnt_d = cnt_q - 1'b1;
            end else if (tc) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = CNT_FULL;
               end
            end
         end
         S_DATA: begin
            if (i_tick && (cnt_q != '0)) begin
               cnt_d = cnt_q - 1'b1;
            end else if (tc) begin
               shift_d = {rx_s_q, shift_q[NB_DATA-1:1]};
               cnt_d   = CNT_FULL;
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (i_tick && (cnt_q != '0)) begin
               cnt_d = cnt_q - 1'b1;
            end else if (tc) begin
               par_pend_d = ((^shift_q) ^ rx_s_q) != i_parity_odd;
               cnt_d      = CNT_FULL;
               state_d    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (i_tick && (cnt_q != '0)) begin
               cnt_d = cnt_q - 1'b1;
            end else if (tc) begin
               stop_err_d = stop_err_q | ~rx_s_q;
               cnt_d      = CNT_FULL;
               if (bit_q == LAST_STOP) begin
                  data_d   = shift_q;
                  ferr_d   = stop_err_q | ~rx_s_q;
                  rxdone_d = 1'b1;
                  state_d  = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  perr_d   = par_pend_q;
`endif
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_data      = data_q;
   assign o_rxdone    = rxdone_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = perr_q;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: two instances (1 and 2 stop bits) checked every cycle against a frame-level model.
// Frames include a parity bit when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps

module tb_uart_rx_cfg;
   localparam int BIT = 64;   // clk per bit: 16 ticks, one tick every 4 clk
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, tick, podd;
   logic       rx [2];
   logic [7:0] dat_o [2];
   logic       done_o [2], ferr_o [2], perr_o [2], busy_o [2];

   int tests = 0, fails = 0, cyc = 0, tick_ph = 0;

   // Frame-level model: one pending expectation per instance plus the values outputs must hold.
   bit         pend [2];
   logic [7:0] exp_data [2], cur_data [2];
   logic       exp_ferr [2], exp_perr [2], cur_ferr [2], cur_perr [2];
   int         edge_cyc [2];
   int         pulses [2];

   uart_rx_cfg #(.NB_DATA(8), .NB_STOP(1), .OVERSAMPLE(16)) u_dut0 (
      .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[0]),
`ifdef UART_RX_PARITY_EN
      .i_parity_odd(podd),
`endif
      .o_data(dat_o[0]), .o_rxdone(done_o[0]), .o_frame_err(ferr_o[0]),
      .o_parity_err(perr_o[0]), .o_busy(busy_o[0]));

   uart_rx_cfg #(.NB_DATA(8), .NB_STOP(2), .OVERSAMPLE(16)) u_dut1 (
      .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[1]),
`ifdef UART_RX_PARITY_EN
      .i_parity_odd(podd),
`endif
      .o_data(dat_o[1]), .o_rxdone(done_o[1]), .o_frame_err(ferr_o[1]),
      .o_parity_err(perr_o[1]), .o_busy(busy_o[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk); #1;
         tick    = (tick_ph == 3);
         tick_ph = (tick_ph + 1) % 4;
      end
   end

   function automatic int nstop(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic int frame_bits(input int d);
      return 1 + 8 + PB + nstop(d);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic v, input int n);
      rx[d] = v;
      step(n);
   endtask

   task automatic send_frame(input int d, input logic [7:0] dat, input logic [1:0] stops,
                             input logic pbit, input int gap);
      logic fe;
      chk($sformatf("dut%0d_prev_frame_done", d), pend[d], 0);
      fe = 1'b0;
      for (int i = 0; i < nstop(d); i++) if (!stops[i]) fe = 1'b1;
      exp_data[d] = dat;
      exp_ferr[d] = fe;
      exp_perr[d] = (PB == 1) ? (((^dat) ^ pbit) != podd) : 1'b0;
      pend[d]     = 1'b1;
      edge_cyc[d] = cyc;
      drive(d, 1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(d, dat[i], BIT);
      if (PB == 1) drive(d, pbit, BIT);
      for (int i = 0; i < nstop(d); i++) begin
         // A zero last stop bit is shortened so the line is high again when the
         // receiver re-checks the start bit it sees right after rxdone.
         if (i == nstop(d) - 1 && !stops[i]) begin
            drive(d, 1'b0, 44);
            drive(d, 1'b1, BIT - 44);
         end else begin
            drive(d, stops[i], BIT);
         end
      end
      chk($sformatf("dut%0d_rxdone_seen", d), pend[d], 0);
      pend[d] = 1'b0;
      drive(d, 1'b1, gap * BIT);
   endtask

   // Compare process: outputs are meaningful every cycle (reset zeros, rxdone frames, held values).
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            chk($sformatf("dut%0d_rst_data", d), dat_o[d], 0);
            chk($sformatf("dut%0d_rst_rxdone", d), done_o[d], 0);
            chk($sformatf("dut%0d_rst_ferr", d), ferr_o[d], 0);
            chk($sformatf("dut%0d_rst_perr", d), perr_o[d], 0);
            chk($sformatf("dut%0d_rst_busy", d), busy_o[d], 0);
         end else if (done_o[d]) begin
            pulses[d]++;
            chk($sformatf("dut%0d_rxdone_expected", d), pend[d], 1);
            if (pend[d]) begin
               int lat, lo;
               lat = cyc - edge_cyc[d];
               lo  = (frame_bits(d) - 1) * BIT + 16;
               chk($sformatf("dut%0d_data", d), dat_o[d], exp_data[d]);
               chk($sformatf("dut%0d_ferr", d), ferr_o[d], exp_ferr[d]);
               chk($sformatf("dut%0d_perr", d), perr_o[d], exp_perr[d]);
               chk($sformatf("dut%0d_latency_in_window_lat%0d", d, lat),
                   (lat >= lo) && (lat <= lo + 32), 1);
               cur_data[d] = exp_data[d];
               cur_ferr[d] = exp_ferr[d];
               cur_perr[d] = exp_perr[d];
               pend[d]     = 1'b0;
            end
         end else begin
            chk($sformatf("dut%0d_hold_data", d), dat_o[d], cur_data[d]);
            chk($sformatf("dut%0d_hold_ferr", d), ferr_o[d], cur_ferr[d]);
            chk($sformatf("dut%0d_hold_perr", d), perr_o[d], cur_perr[d]);
         end
      end
   end

   initial begin
      #3ms;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, fr, d, gap;
      logic [7:0] dat;
      logic [1:0] stops;
      logic pbit;
      rst_n = 1'b0;
      podd  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rx[i] = 1'b1; pend[i] = 1'b0; pulses[i] = 0; edge_cyc[i] = 0;
         exp_data[i] = '0; exp_ferr[i] = 1'b0; exp_perr[i] = 1'b0;
         cur_data[i] = '0; cur_ferr[i] = 1'b0; cur_perr[i] = 1'b0;
      end
      step(6);
      chk("reset_data", dat_o[0], 8'h00);
      chk("reset_busy", busy_o[1], 0);
      rst_n = 1'b1;
      step(10);

      // 0x55, valid stop
      send_frame(0, 8'h55, 2'b11, 1'b0, 1);
      chk("f55_data", dat_o[0], 8'h55);
      chk("f55_ferr", ferr_o[0], 0);
      chk("f55_perr", perr_o[0], 0);
      chk("f55_busy_after", busy_o[0], 0);

      // start glitch of 5 ticks
      p0 = pulses[0];
      drive(0, 1'b0, 20);
      drive(0, 1'b1, 3 * BIT);
      chk("glitch_no_rxdone", pulses[0] - p0, 0);
      chk("glitch_busy", busy_o[0], 0);
      chk("glitch_data_kept", dat_o[0], 8'h55);

      // 0xA3 with stop bit 0 (0xA3 has even weight, parity bit 0 is valid even parity)
      send_frame(0, 8'hA3, 2'b10, 1'b0, 2);
      chk("fA3_data", dat_o[0], 8'hA3);
      chk("fA3_ferr", ferr_o[0], 1);

`ifdef UART_RX_PARITY_EN
      podd = 1'b0;
      send_frame(0, 8'h07, 2'b11, 1'b0, 1);
      chk("f07_par0_perr", perr_o[0], 1);
      send_frame(0, 8'h07, 2'b11, 1'b1, 1);
      chk("f07_par1_perr", perr_o[0], 0);
`endif

      // back-to-back 0x12, 0x34 on the two-stop-bit instance
      p0 = pulses[1];
      send_frame(1, 8'h12, 2'b11, 1'b0, 0);
      chk("b2b_first_data", dat_o[1], 8'h12);
      send_frame(1, 8'h34, 2'b11, 1'b1, 1);
      chk("b2b_second_data", dat_o[1], 8'h34);
      chk("b2b_pulse_count", pulses[1] - p0, 2);

      // reset during data bit 4, then 0xC9
      p0 = pulses[1];
      drive(1, 1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(1, dat_o[1][i] ^ 1'b1, BIT);
      drive(1, 1'b0, 32);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cur_data[i] = '0; cur_ferr[i] = 1'b0; cur_perr[i] = 1'b0;
      end
      step(8);
      rx[1] = 1'b1;
      step(4);
      rst_n = 1'b1;
      step(2 * BIT);
      chk("rst_abort_no_rxdone", pulses[1] - p0, 0);
      chk("rst_abort_data", dat_o[1], 8'h00);
      chk("rst_abort_busy", busy_o[1], 0);
      send_frame(1, 8'hC9, 2'b11, 1'b0, 1);
      chk("fC9_data", dat_o[1], 8'hC9);
      chk("fC9_ferr", ferr_o[1], 0);

      // break: line low for a whole frame plus half a bit
      fr = frame_bits(0);
      podd = 1'b0;
      chk("brk_prev_done", pend[0], 0);
      exp_data[0] = 8'h00; exp_ferr[0] = 1'b1;
      exp_perr[0] = (PB == 1) ? (1'b0 != podd) : 1'b0;
      pend[0] = 1'b1;
      edge_cyc[0] = cyc;
      drive(0, 1'b0, fr * BIT);
      chk("brk_rxdone_seen", pend[0], 0);
      chk("brk_data", dat_o[0], 8'h00);
      chk("brk_ferr", ferr_o[0], 1);
      exp_data[0] = 8'hFF; exp_ferr[0] = 1'b0;
      exp_perr[0] = (PB == 1) ? (1'b1 != podd) : 1'b0;
      pend[0] = 1'b1;
      edge_cyc[0] = edge_cyc[0] + (fr - 1) * BIT + 32;
      drive(0, 1'b0, 32);
      drive(0, 1'b1, fr * BIT);
      chk("brk_restart_rxdone_seen", pend[0], 0);
      pend[0] = 1'b0;
      chk("brk_restart_data", dat_o[0], 8'hFF);

      // randomized frames
      for (int n = 0; n < 40; n++) begin
         d     = $urandom_range(0, 1);
         dat   = 8'($urandom);
         podd  = 1'($urandom_range(0, 1));
         pbit  = 1'($urandom_range(0, 1));
         stops = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         gap   = stops[nstop(d) - 1] ? $urandom_range(0, 2) : $urandom_range(2, 3);
         send_frame(d, dat, stops, pbit, gap);
      end

      step(2 * BIT);
      chk("end_idle_dut0", busy_o[0], 0);
      chk("end_idle_dut1", busy_o[1], 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
